cc_rdata_arbiter: RTL and testbench

- Shares the single upstream 64-bit read-data channel (toward the interconnect) between two serializer sources.
  - Hit path: serializer fed by the cache-hit data FIFO.
  - Miss path: serializer fed by the refill FIFO.
- Arbitrates at burst granularity; every burst is an 8-beat wrapping burst terminated by rlast.
- A grant is held until the rlast handshake.
- Hit has priority, with a bounded streak so the miss path cannot starve.

---
 rtl/cc_rarb_pkg.sv | 26 ++
 rtl/cc_rarb_pick.sv | 21 ++
 rtl/cc_rdata_arbiter.sv | 144 ++++++++++++++
 tb/tb_cc_rdata_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_rarb_pkg.sv
// Shared types and constants for the read-data channel arbiter.
// Optional beat-count checker in the top is enabled by the CC_RARB_BEATCHK_EN macro.
package cc_rarb_pkg;

    localparam int unsigned CC_DATA_W     = 64;
    localparam int unsigned CC_BURST_LEN  = 8;
    localparam int unsigned CC_BEAT_CNT_W = $clog2(CC_BURST_LEN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_HIT  = 2'd1,
        GNT_MISS = 2'd2
    } cc_rarb_state_e;

    typedef enum logic {
        SRC_HIT  = 1'b0,
        SRC_MISS = 1'b1
    } cc_rarb_src_e;

    // One read-data beat as seen on the upstream channel.
    typedef struct packed {
        logic [CC_DATA_W-1:0] data;
        logic                 last;
    } cc_rbeat_t;

endpackage

// File: rtl/cc_rarb_pick.sv
// Combinational burst-level pick: hit wins unless its streak hit the limit.
module cc_rarb_pick
    import cc_rarb_pkg::*;
(
    input  logic         hit_req,
    input  logic         miss_req,
    input  logic         streak_at_limit,
    output logic         pick_valid_c,
    output cc_rarb_src_e pick_src_c
);

    // Priority pick with starvation escape for the miss path.
    always_comb begin
        pick_valid_c = hit_req | miss_req;
        pick_src_c   = SRC_HIT;
        if (miss_req && (!hit_req || streak_at_limit)) begin
            pick_src_c = SRC_MISS;
        end
    end

endmodule

// File: rtl/cc_rdata_arbiter.sv
// Burst-granular arbiter sharing the upstream read-data channel between the
// hit and miss serializers. Optional macro CC_RARB_BEATCHK_EN adds a sticky
// burst-length checker driving beat_err_o.
module cc_rdata_arbiter
    import cc_rarb_pkg::*;
#(
    parameter int unsigned HIT_PRIO_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CC_DATA_W-1:0] hit_rdata_i,
    input  logic                 hit_rlast_i,
    input  logic                 hit_rvalid_i,
    output logic                 hit_rready_o,
    input  logic [CC_DATA_W-1:0] miss_rdata_i,
    input  logic                 miss_rlast_i,
    input  logic                 miss_rvalid_i,
    output logic                 miss_rready_o,
    output logic [CC_DATA_W-1:0] rdata_o,
    output logic                 rlast_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic                 rsrc_o,
    output logic                 busy_o,
    output logic                 beat_err_o
);

    localparam int unsigned STREAK_W = $clog2(HIT_PRIO_LIMIT + 1);

    cc_rarb_state_e      state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    cc_rbeat_t           up_beat_c;
    logic                up_hs_c;
    logic                last_hs_c;
    logic                decide_c;
    logic                at_limit_c;
    logic                pick_valid_c;
    cc_rarb_src_e        pick_src_c;

    assign up_hs_c    = rvalid_o & rready_i;
    assign last_hs_c  = up_hs_c & rlast_o;
    assign decide_c   = (state_q == IDLE) | last_hs_c;
    assign at_limit_c = (streak_q == STREAK_W'(HIT_PRIO_LIMIT));

    cc_rarb_pick u_pick (
        .hit_req         (hit_rvalid_i),
        .miss_req        (miss_rvalid_i),
        .streak_at_limit (at_limit_c),
        .pick_valid_c    (pick_valid_c),
        .pick_src_c      (pick_src_c)
    );

    // Pass-through mux: the granted source drives the channel, the other is held off.
    always_comb begin
        up_beat_c     = '0;
        rvalid_o      = 1'b0;
        hit_rready_o  = 1'b0;
        miss_rready_o = 1'b0;
        case (state_q)
            GNT_HIT: begin
                up_beat_c    = '{data: hit_rdata_i, last: hit_rlast_i};
                rvalid_o     = hit_rvalid_i;
                hit_rready_o = rready_i;
            end
            GNT_MISS: begin
                up_beat_c     = '{data: miss_rdata_i, last: miss_rlast_i};
                rvalid_o      = miss_rvalid_i;
                miss_rready_o = rready_i;
            end
            default: ;
        endcase
    end

    assign rdata_o = up_beat_c.data;
    assign rlast_o = up_beat_c.last;

    // Next grant and streak, evaluated only in IDLE or on the last handshake.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        if (decide_c) begin
            if (!pick_valid_c) begin
                state_d = IDLE;
            end else if (pick_src_c == SRC_MISS) begin
                state_d  = GNT_MISS;
                streak_d = '0;
            end else begin
                state_d = GNT_HIT;
                if (!miss_rvalid_i) begin
                    streak_d = '0;
                end else if (!at_limit_c) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end
        end
    end

    // Grant state, streak and registered grant status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            streak_q <= '0;
            busy_o   <= 1'b0;
            rsrc_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            busy_o   <= (state_d != IDLE);
            rsrc_o   <= (state_d == GNT_MISS);
        end
    end

`ifdef CC_RARB_BEATCHK_EN
    localparam logic [CC_BEAT_CNT_W-1:0] LAST_IDX = CC_BEAT_CNT_W'(CC_BURST_LEN - 1);

    logic [CC_BEAT_CNT_W-1:0] beat_cnt_q;
    logic                     beat_err_q;

    // Count upstream beats; flag a short burst or a missing rlast, sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
            beat_err_q <= 1'b0;
        end else if (up_hs_c) begin
            if (rlast_o) begin
                beat_cnt_q <= '0;
                if (beat_cnt_q != LAST_IDX) begin
                    beat_err_q <= 1'b1;
                end
            end else begin
                beat_cnt_q <= beat_cnt_q + CC_BEAT_CNT_W'(1);
                if (beat_cnt_q == LAST_IDX) begin
                    beat_err_q <= 1'b1;
                end
            end
        end
    end

    assign beat_err_o = beat_err_q;
`else
    assign beat_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cc_rdata_arbiter.sv
// Self-checking bench for cc_rdata_arbiter: vector table plus directed sequences.
module tb_cc_rdata_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic [63:0] hit_rdata_i;
    logic        hit_rlast_i;
    logic        hit_rvalid_i;
    logic        hit_rready_o;
    logic [63:0] miss_rdata_i;
    logic        miss_rlast_i;
    logic        miss_rvalid_i;
    logic        miss_rready_o;
    logic [63:0] rdata_o;
    logic        rlast_o;
    logic        rvalid_o;
    logic        rready_i;
    logic        rsrc_o;
    logic        busy_o;
    logic        beat_err_o;

    int n_checks;
    int n_pass;

    cc_rdata_arbiter #(.HIT_PRIO_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hit_rdata_i   (hit_rdata_i),
        .hit_rlast_i   (hit_rlast_i),
        .hit_rvalid_i  (hit_rvalid_i),
        .hit_rready_o  (hit_rready_o),
        .miss_rdata_i  (miss_rdata_i),
        .miss_rlast_i  (miss_rlast_i),
        .miss_rvalid_i (miss_rvalid_i),
        .miss_rready_o (miss_rready_o),
        .rdata_o       (rdata_o),
        .rlast_o       (rlast_o),
        .rvalid_o      (rvalid_o),
        .rready_i      (rready_i),
        .rsrc_o        (rsrc_o),
        .busy_o        (busy_o),
        .beat_err_o    (beat_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hv;
        logic        hl;
        logic [63:0] hd;
        logic        mv;
        logic        rr;
        logic        ev;
        logic        el;
        logic        ehr;
        logic        emr;
        logic        eb;
        logic        es;
        logic [63:0] ed;
    } vec_t;

    vec_t tbl[$];

    // Observed outputs packed {rvalid, rlast, hit_rready, miss_rready, busy, rsrc, rdata}.
    function automatic logic [69:0] obs();
        return {rvalid_o, rlast_o, hit_rready_o, miss_rready_o, busy_o, rsrc_o, rdata_o};
    endfunction

    function automatic logic [69:0] pack_exp(input logic v, input logic l, input logic hr,
                                             input logic mr, input logic b, input logic s,
                                             input logic [63:0] d);
        return {v, l, hr, mr, b, s, d};
    endfunction

    function automatic logic [63:0] mkdata(input int src, input int burst, input int beat);
        logic [7:0] tag;
        tag = (src != 0) ? 8'hB0 : 8'hA0;
        return {48'h0, tag, 4'(burst), 4'(beat)};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic hv, input logic hl, input logic [63:0] hd,
                         input logic mv, input logic ml, input logic [63:0] md,
                         input logic rr);
        hit_rvalid_i  = hv;
        hit_rlast_i   = hl;
        hit_rdata_i   = hd;
        miss_rvalid_i = mv;
        miss_rlast_i  = ml;
        miss_rdata_i  = md;
        rready_i      = rr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int hv_a[14];
        int ix_a[14];
        int rr_a[14];
        int ord[10];
        int hk, mk, hb, mb;
        logic hh, mh;

        n_checks = 0;
        n_pass   = 0;

        // ---------------- vector table ----------------
        tbl.push_back('{1'b1, 1'b0, 64'h0, 1'b0, 1'b1,
                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0});
        for (int k = 0; k < 8; k++) begin
            tbl.push_back('{1'b1, (k == 7), 64'(k), 1'b0, 1'b1,
                            1'b1, (k == 7), 1'b1, 1'b0, 1'b1, 1'b0, 64'(k)});
        end
        // Hit was still valid on its last handshake, so hit keeps the grant.
        tbl.push_back('{1'b0, 1'b0, 64'h0, 1'b0, 1'b1,
                        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0});
        // Stalled hit burst: rready toggling, bubble at beat 3, miss raised mid-burst.
        hv_a = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        ix_a = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 7, 7};
        rr_a = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 1};
        for (int i = 0; i < 14; i++) begin
            tbl.push_back('{1'(hv_a[i]), (ix_a[i] == 7), 64'(32'h10 + ix_a[i]), (i != 0),
                            1'(rr_a[i]),
                            1'(hv_a[i]), (ix_a[i] == 7), 1'(rr_a[i]), 1'b0, 1'b1, 1'b0,
                            64'(32'h10 + ix_a[i])});
        end
        // Both requesting at the last handshake with streak 0: hit is picked again.
        tbl.push_back('{1'b0, 1'b0, 64'h0, 1'b1, 1'b1,
                        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0});

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        @(negedge clk);
        check("reset_outputs", obs(), '0);
        check("reset_beat_err", 70'(beat_err_o), 70'(0));
        do_reset();

        // ---------------- table run ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].hv, tbl[i].hl, tbl[i].hd, tbl[i].mv, 1'b0, 64'hDEAD_BEEF, tbl[i].rr);
            @(negedge clk);
            check($sformatf("vec%0d", i), obs(),
                  pack_exp(tbl[i].ev, tbl[i].el, tbl[i].ehr, tbl[i].emr,
                           tbl[i].eb, tbl[i].es, tbl[i].ed));
            next_cycle();
        end

        // ---------------- both sources continuous ----------------
        do_reset();
        ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        hk = 0; mk = 0; hb = 0; mb = 0;
        drive(1'b1, 1'b0, mkdata(0, 0, 0), 1'b1, 1'b0, mkdata(1, 0, 0), 1'b1);
        @(negedge clk);
        check("cont_idle", obs(), pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0));
        next_cycle();
        for (int c = 0; c < 80; c++) begin
            int b, k, s, nb;
            drive(1'b1, (hk == 7), mkdata(0, hb, hk), 1'b1, (mk == 7), mkdata(1, mb, mk), 1'b1);
            @(negedge clk);
            b  = c / 8;
            k  = c % 8;
            s  = ord[b];
            nb = 0;
            for (int j = 0; j < b; j++) if (ord[j] == s) nb++;
            check($sformatf("cont_c%0d", c), obs(),
                  pack_exp(1'b1, (k == 7), (s == 0), (s == 1), 1'b1, 1'(s), mkdata(s, nb, k)));
            hh = hit_rvalid_i && hit_rready_o;
            mh = miss_rvalid_i && miss_rready_o;
            next_cycle();
            if (hh) begin
                if (hk == 7) begin hk = 0; hb++; end else hk++;
            end
            if (mh) begin
                if (mk == 7) begin mk = 0; mb++; end else mk++;
            end
        end
        check("cont_no_beat_err", 70'(beat_err_o), 70'(0));

        // ---------------- async reset mid miss burst ----------------
        do_reset();
        drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, mkdata(1, 0, 0), 1'b1);
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 64'h0, 1'b1, 1'b0, mkdata(1, 0, k), 1'b1);
            @(negedge clk);
            check($sformatf("rstmid_beat%0d", k), obs(),
                  pack_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mkdata(1, 0, k)));
            if (k == 4) begin
                #1 rst_n = 1'b0;
                #1 check("rstmid_async_clear", obs(), '0);
            end
            next_cycle();
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, mkdata(0, 0, 0), 1'b0, 1'b0, 64'h0, 1'b1);
        @(negedge clk);
        check("rstmid_idle", obs(), pack_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0));
        next_cycle();
        @(negedge clk);
        check("rstmid_hit_grant", obs(),
              pack_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, mkdata(0, 0, 0)));
        next_cycle();

`ifdef CC_RARB_BEATCHK_EN
        // ---------------- short burst flagged by the beat checker ----------------
        do_reset();
        drive(1'b1, 1'b0, mkdata(0, 0, 0), 1'b0, 1'b0, 64'h0, 1'b1);
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, (k == 5), mkdata(0, 0, k), 1'b0, 1'b0, 64'h0, 1'b1);
            @(negedge clk);
            if (k == 5) check("err_not_early", 70'(beat_err_o), 70'(0));
            next_cycle();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, (k == 7), mkdata(0, 1, k), 1'b0, 1'b0, 64'h0, 1'b1);
            @(negedge clk);
            if (k == 0) check("err_set", 70'(beat_err_o), 70'(1));
            check($sformatf("err_next_beat%0d", k), obs(),
                  pack_exp(1'b1, (k == 7), 1'b1, 1'b0, 1'b1, 1'b0, mkdata(0, 1, k)));
            next_cycle();
        end
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1);
        @(negedge clk);
        check("err_sticky", 70'(beat_err_o), 70'(1));
`else
        check("err_tied_low", 70'(beat_err_o), 70'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
